// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and RAM-port signals shared by the core-side
// memory arbiter. The arbiter uses the slave view. The core/RAM side uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 6
);
  // Instruction-fetch side
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;

  // Load/store side
  logic              dm_ren;
  logic              dm_wen;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;

  // Core status
  logic              misaligned;
  logic              stall;

  // Single-port RAM with registered read
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, misaligned, stall,
           mem_addr, mem_wen, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, misaligned, stall,
           mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one registered-read RAM port between the
// instruction-fetch path and the load/store path. Each access takes
// IDLE/RESP -> ACCESS -> RESP. The ack and read data appear in RESP.
module mem_port_arbiter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  typedef enum logic {SIDE_IF, SIDE_DM} side_t;

  state_t            state_q, state_d;
  side_t             owner_q, owner_d;
  side_t             last_q, last_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              store_q, store_d;      // current DM access is a store (no read-back)
  logic              mis_q, mis_d;          // current access had a non-word-aligned address
  logic [31:0]       if_hold_q, if_hold_d;
  logic [31:0]       dm_hold_q, dm_hold_d;

  logic              dm_req;
  logic              grant_if;
  logic              grant_dm;
  logic              if_ack_c;
  logic              dm_ack_c;
  logic              unused_addr_bits;

  assign dm_req = bus.dm_ren | bus.dm_wen;

  // Upper address bits are intentionally dropped, so addresses wrap modulo the RAM size.
  assign unused_addr_bits = &{1'b0, bus.if_addr[31:ADDR_W+2], bus.dm_addr[31:ADDR_W+2]};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= SIDE_IF;
      last_q      <= SIDE_DM;   // fetch wins the first contention
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      store_q     <= 1'b0;
      mis_q       <= 1'b0;
      if_hold_q   <= '0;
      dm_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      store_q     <= store_d;
      mis_q       <= mis_d;
      if_hold_q   <= if_hold_d;
      dm_hold_q   <= dm_hold_d;
    end
  end

  // Arbitration: round-robin in IDLE; in RESP only the non-owner may be granted
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.if_req && (!dm_req || last_q == SIDE_DM)) grant_if = 1'b1;
        else if (dm_req)                                  grant_dm = 1'b1;
      end
      ST_RESP: begin
        if (owner_q == SIDE_IF) grant_dm = dm_req;
        else                    grant_if = bus.if_req;
      end
      default: ;
    endcase
  end

  // Next-state and register-load logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = 1'b0;          // write strobe lasts only the ACCESS cycle
    mem_wdata_d = mem_wdata_q;
    store_d     = store_q;
    mis_d       = mis_q;
    if_hold_d   = if_hold_q;
    dm_hold_d   = dm_hold_q;

    // Capture the returned word as the RESP cycle ends
    if (state_q == ST_RESP) begin
      if (owner_q == SIDE_IF) if_hold_d = bus.mem_rdata;
      else if (!store_q)      dm_hold_d = bus.mem_rdata;
    end

    case (state_q)
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = (grant_if || grant_dm) ? ST_ACCESS : ST_IDLE;
    endcase

    if (grant_if) begin
      owner_d    = SIDE_IF;
      last_d     = SIDE_IF;
      mem_addr_d = bus.if_addr[ADDR_W+1:2];
      store_d    = 1'b0;
      mis_d      = (bus.if_addr[1:0] != 2'b00);
    end else if (grant_dm) begin
      owner_d     = SIDE_DM;
      last_d      = SIDE_DM;
      mem_addr_d  = bus.dm_addr[ADDR_W+1:2];
      mem_wen_d   = bus.dm_wen;
      mem_wdata_d = bus.dm_wdata;
      store_d     = bus.dm_wen;   // ren+wen together is treated as a store
      mis_d       = (bus.dm_addr[1:0] != 2'b00);
    end
  end

  // Outputs: acks and live read data in RESP, hold registers otherwise
  always_comb begin
    if_ack_c       = (state_q == ST_RESP) && (owner_q == SIDE_IF);
    dm_ack_c       = (state_q == ST_RESP) && (owner_q == SIDE_DM);
    bus.if_ack     = if_ack_c;
    bus.dm_ack     = dm_ack_c;
    bus.if_rdata   = if_ack_c ? bus.mem_rdata : if_hold_q;
    bus.dm_rdata   = (dm_ack_c && !store_q) ? bus.mem_rdata : dm_hold_q;
    bus.misaligned = (state_q == ST_RESP) && mis_q;
    bus.stall      = (bus.if_req & ~if_ack_c) | (dm_req & ~dm_ack_c);
    bus.mem_addr   = mem_addr_q;
    bus.mem_wen    = mem_wen_q;
    bus.mem_wdata  = mem_wdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural registered-read RAM.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: write and registered read at the rising edge, plus a preload port
  logic [31:0] ram [0:63];
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;

  always @(posedge clk) begin
    if (load_en)          ram[load_addr]    <= load_data;
    else if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_ren = 1'b0; bus.dm_wen = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    load_en = 1'b1; load_addr = '0; load_data = '0;

    // Preload RAM under reset
    for (int i = 0; i < 64; i++) begin
      load_addr = 6'(i);
      load_data = (i == 3) ? 32'h00A0_0093 : (i == 1) ? 32'h1111_1111 : 32'h0;
      cyc;
    end
    load_en = 1'b0;
    cyc;
    rst = 1'b0;
    smp;
    chk("rst_if_ack",    32'(bus.if_ack), 32'd0);
    chk("rst_dm_ack",    32'(bus.dm_ack), 32'd0);
    chk("rst_misalign",  32'(bus.misaligned), 32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wen",   32'(bus.mem_wen), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_if_rdata",  bus.if_rdata, 32'd0);
    chk("rst_dm_rdata",  bus.dm_rdata, 32'd0);
    chk("rst_stall",     32'(bus.stall), 32'd0);

    // Fetch only
    $display("txn: fetch 0x0C");
    cyc; bus.if_req = 1'b1; bus.if_addr = 32'h0C; smp;
    chk("t1_c0_stall", 32'(bus.stall), 32'd1);
    chk("t1_c0_ack",   32'(bus.if_ack), 32'd0);
    cyc; smp;
    chk("t1_c1_mem_addr", 32'(bus.mem_addr), 32'd3);
    chk("t1_c1_stall",    32'(bus.stall), 32'd1);
    chk("t1_c1_ack",      32'(bus.if_ack), 32'd0);
    cyc; smp;
    chk("t1_c2_ack",    32'(bus.if_ack), 32'd1);
    chk("t1_c2_rdata",  bus.if_rdata, 32'h00A0_0093);
    chk("t1_c2_stall",  32'(bus.stall), 32'd0);
    chk("t1_c2_mis",    32'(bus.misaligned), 32'd0);
    cyc; bus.if_req = 1'b0; smp;
    chk("t1_c3_ack",    32'(bus.if_ack), 32'd0);
    chk("t1_c3_hold",   bus.if_rdata, 32'h00A0_0093);

    // Store then load
    $display("txn: store 0xDEADBEEF to 0x10");
    cyc; bus.dm_wen = 1'b1; bus.dm_addr = 32'h10; bus.dm_wdata = 32'hDEAD_BEEF; smp;
    chk("t2_c0_stall", 32'(bus.stall), 32'd1);
    cyc; smp;
    chk("t2_c1_wen",   32'(bus.mem_wen), 32'd1);
    chk("t2_c1_addr",  32'(bus.mem_addr), 32'd4);
    chk("t2_c1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t2_c1_ack",   32'(bus.dm_ack), 32'd0);
    cyc; smp;
    chk("t2_c2_ack",   32'(bus.dm_ack), 32'd1);
    chk("t2_c2_wen",   32'(bus.mem_wen), 32'd0);
    chk("t2_c2_rdata", bus.dm_rdata, 32'd0);
    $display("txn: load 0x10");
    cyc; bus.dm_wen = 1'b0; bus.dm_ren = 1'b1; smp;
    chk("t2_c3_ack",   32'(bus.dm_ack), 32'd0);
    cyc; smp;
    chk("t2_c4_wen",   32'(bus.mem_wen), 32'd0);
    cyc; smp;
    chk("t2_c5_ack",   32'(bus.dm_ack), 32'd1);
    chk("t2_c5_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
    cyc; bus.dm_ren = 1'b0; smp;

    // Simultaneous requests after reset, held continuously
    $display("txn: contention fetch 0x0C / load 0x10");
    cyc; rst = 1'b1; smp;
    cyc; rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0C; bus.dm_ren = 1'b1; bus.dm_addr = 32'h10; smp;
    chk("t3_c0_dm_hold", bus.dm_rdata, 32'd0);
    chk("t3_c0_stall",   32'(bus.stall), 32'd1);
    cyc; smp;
    chk("t3_c1_addr",    32'(bus.mem_addr), 32'd3);
    cyc; smp;
    chk("t3_c2_if_ack",  32'(bus.if_ack), 32'd1);
    chk("t3_c2_dm_ack",  32'(bus.dm_ack), 32'd0);
    chk("t3_c2_rdata",   bus.if_rdata, 32'h00A0_0093);
    cyc; smp;
    chk("t3_c3_addr",    32'(bus.mem_addr), 32'd4);
    chk("t3_c3_dm_ack",  32'(bus.dm_ack), 32'd0);
    cyc; smp;
    chk("t3_c4_dm_ack",  32'(bus.dm_ack), 32'd1);
    chk("t3_c4_if_ack",  32'(bus.if_ack), 32'd0);
    chk("t3_c4_rdata",   bus.dm_rdata, 32'hDEAD_BEEF);
    cyc; smp;
    chk("t3_c5_if_ack",  32'(bus.if_ack), 32'd0);
    cyc; smp;
    chk("t3_c6_if_ack",  32'(bus.if_ack), 32'd1);
    chk("t3_c6_dm_ack",  32'(bus.dm_ack), 32'd0);
    cyc; smp;
    cyc; smp;
    chk("t3_c8_dm_ack",  32'(bus.dm_ack), 32'd1);
    cyc; bus.if_req = 1'b0; bus.dm_ren = 1'b0; smp;
    chk("t3_c9_stall",   32'(bus.stall), 32'd0);
    cyc; smp;
    chk("t3_c10_withdrawn_ack", 32'(bus.if_ack), 32'd1);

    // Misaligned and wrapped
    $display("txn: load 0x106 (misaligned, wraps)");
    cyc; bus.dm_ren = 1'b1; bus.dm_addr = 32'h106; smp;
    cyc; smp;
    chk("t4_c1_addr",  32'(bus.mem_addr), 32'd1);
    cyc; smp;
    chk("t4_c2_ack",   32'(bus.dm_ack), 32'd1);
    chk("t4_c2_mis",   32'(bus.misaligned), 32'd1);
    chk("t4_c2_rdata", bus.dm_rdata, 32'h1111_1111);
    $display("txn: load 0x104");
    cyc; bus.dm_addr = 32'h104; smp;
    chk("t4_c3_mis",   32'(bus.misaligned), 32'd0);
    cyc; smp;
    chk("t4_c4_addr",  32'(bus.mem_addr), 32'd1);
    cyc; smp;
    chk("t4_c5_ack",   32'(bus.dm_ack), 32'd1);
    chk("t4_c5_mis",   32'(bus.misaligned), 32'd0);
    cyc; bus.dm_ren = 1'b0; smp;

    // Dual enable acts as a store, then load back with a fetch raised at the load ack
    $display("txn: dual-enable store 0xCAFEF00D to 0x20");
    cyc; bus.dm_ren = 1'b1; bus.dm_wen = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'hCAFE_F00D; smp;
    cyc; smp;
    chk("t5_c1_wen",   32'(bus.mem_wen), 32'd1);
    chk("t5_c1_addr",  32'(bus.mem_addr), 32'd8);
    cyc; smp;
    chk("t5_c2_ack",   32'(bus.dm_ack), 32'd1);
    chk("t5_c2_rdata", bus.dm_rdata, 32'h1111_1111);
    $display("txn: load 0x20, fetch 0x20 raised at ack");
    cyc; bus.dm_wen = 1'b0; smp;
    cyc; smp;
    cyc; bus.if_req = 1'b1; bus.if_addr = 32'h20; smp;
    chk("t5_c5_ack",   32'(bus.dm_ack), 32'd1);
    chk("t5_c5_rdata", bus.dm_rdata, 32'hCAFE_F00D);
    chk("t5_c5_stall", 32'(bus.stall), 32'd1);
    cyc; bus.dm_ren = 1'b0; smp;
    chk("t5_c6_addr",  32'(bus.mem_addr), 32'd8);
    cyc; smp;
    chk("t5_c7_if_ack", 32'(bus.if_ack), 32'd1);
    chk("t5_c7_rdata",  bus.if_rdata, 32'hCAFE_F00D);
    cyc; bus.if_req = 1'b0; smp;

    // Reset mid-access of a store, then reset during a load RESP
    $display("txn: store 0x12345678 to 0x14 with reset in ACCESS");
    cyc; bus.dm_wen = 1'b1; bus.dm_addr = 32'h14; bus.dm_wdata = 32'h1234_5678; smp;
    cyc; smp;
    chk("t6_c1_wen",   32'(bus.mem_wen), 32'd1);
    chk("t6_c1_addr",  32'(bus.mem_addr), 32'd5);
    rst = 1'b1; bus.dm_wen = 1'b0;
    cyc; rst = 1'b0; smp;
    chk("t6_c2_ack",   32'(bus.dm_ack), 32'd0);
    chk("t6_c2_wen",   32'(bus.mem_wen), 32'd0);
    chk("t6_c2_addr",  32'(bus.mem_addr), 32'd0);
    chk("t6_c2_wdata", bus.mem_wdata, 32'd0);
    chk("t6_c2_ifhold", bus.if_rdata, 32'd0);
    $display("txn: load 0x14 with reset in RESP");
    cyc; bus.dm_ren = 1'b1; bus.dm_addr = 32'h14; smp;
    cyc; smp;
    chk("t6_c4_addr",  32'(bus.mem_addr), 32'd5);
    cyc; smp;
    chk("t6_c5_ack",   32'(bus.dm_ack), 32'd1);
    chk("t6_c5_rdata", bus.dm_rdata, 32'h1234_5678);
    rst = 1'b1; bus.dm_ren = 1'b0;
    cyc; rst = 1'b0; smp;
    chk("t6_c6_hold",  bus.dm_rdata, 32'd0);
    chk("t6_c6_ack",   32'(bus.dm_ack), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
